// File: rtl/data_mem_sized_if.sv
// rtl/data_mem_sized_if.sv - request/response bus between the datapath and data_mem_sized
interface data_mem_sized_if #(
    parameter int DATA_W = 32
);
    logic              Req;
    logic              MDRW;
    logic [1:0]        Size;
    logic              Unsigned;
    logic [31:0]       DAddr;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] DataOut;
    logic              Ready;
    logic              Busy;
    logic              Err;

    modport master (
        output Req, MDRW, Size, Unsigned, DAddr, DataIn,
        input  DataOut, Ready, Busy, Err
    );

    modport slave (
        input  Req, MDRW, Size, Unsigned, DAddr, DataIn,
        output DataOut, Ready, Busy, Err
    );
endinterface

// File: rtl/data_mem_sized.sv
// rtl/data_mem_sized.sv - byte/half/word data memory with wait states, big-endian lanes and error flag
module data_mem_sized #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    parameter int WAIT   = 1
) (
    input  logic             clk,
    input  logic             Reset,
    data_mem_sized_if.slave  bus
);
    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int AL = $clog2(NB);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              capture;

    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic              uns_q;

    logic [7:0]        mem [DEPTH];
    logic              ready_q;
    logic              err_q;
    logic [DATA_W-1:0] dout_q;

    logic [AW-1:0]     addr_idx;
    logic [32:0]       nbytes;
    logic [32:0]       end_addr;
    logic              acc_err;
    logic [DATA_W-1:0] rd_word;
    logic [15:0]       rd_half;
    logic [7:0]        rd_byte;
    logic [DATA_W-1:0] rd_ext;

    assign addr_idx = addr_q[AW-1:0];

    always_comb begin
        nbytes = '0;
        case (size_q)
            2'b00:   nbytes = 33'd1;
            2'b01:   nbytes = 33'd2;
            2'b10:   nbytes = 33'(NB);
            default: nbytes = '0;
        endcase
    end

    // 33-bit sum so an address near 2^32 cannot wrap back into range
    assign end_addr = {1'b0, addr_q} + nbytes;

    assign acc_err = (size_q == 2'b11)
                   || ((size_q == 2'b01) && addr_q[0])
                   || ((size_q == 2'b10) && (addr_q[AL-1:0] != '0))
                   || (end_addr > 33'(DEPTH));

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NB; k++) begin
            rd_word[DATA_W-1-8*k -: 8] = mem[addr_idx + AW'(k)];
        end
        rd_half = {mem[addr_idx], mem[addr_idx + AW'(1)]};
        rd_byte = mem[addr_idx];
    end

    always_comb begin
        rd_ext = '0;
        case (size_q)
            2'b00:   rd_ext = {{(DATA_W-8){~uns_q & rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = {{(DATA_W-16){~uns_q & rd_half[15]}}, rd_half};
            2'b10:   rd_ext = rd_word;
            default: rd_ext = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        capture  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.Req) begin
                    capture  = 1'b1;
                    cnt_nx   = 4'(WAIT);
                    state_nx = (WAIT > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nx = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (capture) begin
                addr_q  <= bus.DAddr;
                wdata_q <= bus.DataIn;
                wr_q    <= bus.MDRW;
                size_q  <= bus.Size;
                uns_q   <= bus.Unsigned;
            end
            ready_q <= (state == S_ACCESS);
            err_q   <= (state == S_ACCESS) && acc_err;
            if (state == S_ACCESS) begin
                if (acc_err) begin
                    dout_q <= '0;
                end else if (wr_q) begin
                    // lowest address holds the most significant byte of the access
                    case (size_q)
                        2'b00: mem[addr_idx] <= wdata_q[7:0];
                        2'b01: begin
                            mem[addr_idx]            <= wdata_q[15:8];
                            mem[addr_idx + AW'(1)]   <= wdata_q[7:0];
                        end
                        2'b10: begin
                            for (int k = 0; k < NB; k++) begin
                                mem[addr_idx + AW'(k)] <= wdata_q[DATA_W-1-8*k -: 8];
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    dout_q <= rd_ext;
                end
            end
        end
    end

    assign bus.DataOut = dout_q;
    assign bus.Ready   = ready_q;
    assign bus.Err     = err_q;
    assign bus.Busy    = (state != S_IDLE) || ready_q;
endmodule
